seg_pair_decoder: RTL and testbench
===================================

// Module: seg_pair_decoder
// PURPOSE
//  Decodes a two-digit seven-segment display image (tens + ones patterns) back into a
//  binary value 0..99.
//  Input pairs are qualified by a stability filter, so glitching or scanned captures
//  are ignored.
//  Used on the readback/self-check path of the countdown display and for bench
//  scoreboarding.
//  Sits downstream of the two-digit segment encoder.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical valid samples required before a pair is accepted (>=1)
//  ERRCNT_W       8  width of the saturating error counter
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  ten        in   7         tens segment pattern {g,f,e,d,c,b,a}, 1 = segment lit
//  one        in   7         ones segment pattern, same format
//  in_valid   in   1         ten/one are meaningful this cycle
//  number     out  7         decoded value 0..99; 7'd127 when err
//  out_valid  out  1         one-cycle pulse: number/err updated
//  err        out  1         illegal pattern in the accepted pair; qualified by out_valid
//  err_cnt    out  ERRCNT_W  saturating count of erroneous accepts (see CONFIGURATION)
// BEHAVIOUR
//  Reset
//   - Async on rst_n=0: number=0, out_valid=0, err=0, err_cnt=0.
//   - Stability counter and held pair cleared; stage-1 valid cleared.
//   - An in-flight decode is discarded; no out_valid after release.
//  Legal patterns (hex)
//   0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   - ten=00 (leading blank) decodes as tens digit 0.
//   - one=00 is illegal.
//   - Any other pattern on either digit is illegal.
//  Stability filter, per clk edge
//   - in_valid=0: stab_cnt <= 0.
//   - in_valid=1 and {ten,one} != held pair, or stab_cnt==0:
//     held <= {ten,one}, stab_cnt <= 1.
//   - in_valid=1 and {ten,one} == held pair: stab_cnt <= min(stab_cnt+1, STABLE_CYCLES).
//   - Accept fires on the edge where stab_cnt becomes STABLE_CYCLES, never while saturated.
//   - One accept per stable run; a new accept needs a change or an in_valid drop.
//   - STABLE_CYCLES=1: the first valid sample of each new pair is accepted.
//  Pipeline
//   - Stage 1, on the accept edge: decode both digits into tens_d/ones_d (4b) plus
//     illegal flags; s1_valid <= 1.
//   - Stage 2, next edge: number <= tens_d*10 + ones_d (<=99, fits 7b);
//     err <= illegal_t | illegal_o.
//   - On err, number <= 127.
//   - out_valid <= s1_valid.
//   - Latency: out_valid high for exactly one cycle, beginning one edge after the
//     STABLE_CYCLES-th identical sample edge.
//   - number/err hold their values between pulses.
//  Boundaries
//   - Pair change on the accept edge: the change is sampled next cycle and restarts the filter.
//   - Back-to-back accepts are possible only with STABLE_CYCLES=1; the pipeline
//     accepts one pair per cycle, no stall.
//   - No output backpressure.
// CONFIGURATION
//  SEGDEC_ERRCNT_EN
//   - Defined: err_cnt increments on each out_valid&err and saturates at all-ones.
//   - Undefined: err_cnt is tied to 0 and the counter logic is absent.
//   - Port list is identical in both builds.
// TESTING
//  1 rst_n=0 with random inputs -> number=0, out_valid=0, err=0, err_cnt=0; hold after release with in_valid=0.
//  2 ten=5B, one=4F, in_valid=1 for 4 cycles -> single out_valid pulse one edge after 4th sample; number=23, err=0; hold 10 more cycles -> no further pulse.
//  3 ten=00, one=07 stable 4 cycles -> number=7; then ten=6F, one=6F, 3 samples, then one=7F -> no pulse; hold 4 -> number=98.
//  4 ten=06, one=01 stable 4 cycles -> err=1, number=127; err_cnt=1 with SEGDEC_ERRCNT_EN, 0 without; force 2^ERRCNT_W+2 errors -> saturates.
//  5 in_valid dropped for 1 cycle mid-run of 3F/3F -> filter restarts; pulse with number=0 only after 4 new samples.
//  6 rst_n pulsed low on the accept edge (stage 1 loaded) -> no out_valid after release; outputs stay at reset values.

Source files
------------

// File: rtl/seg_pair_decoder.sv
// ---------------------------------------------------------------------------
// seg_pair_decoder
//
// Turns a two-digit seven-segment image (tens + ones) back into a binary value
// 0..99. The input pair must be stable for STABLE_CYCLES consecutive valid
// samples before it is decoded, so glitching or scanned captures are ignored.
// Each stable run produces exactly one decode.
//
// Parameters
//   STABLE_CYCLES  identical valid samples needed before a pair is accepted (>=1)
//   ERRCNT_W       width of the saturating error counter
//
// Optional feature (compile-time macro)
//   SEGDEC_ERRCNT_EN  when defined, err_cnt counts erroneous accepts and
//                     saturates at all-ones; when undefined, err_cnt is 0.
//                     The port list is the same in both builds.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   ten        tens pattern {g,f,e,d,c,b,a}, 1 = segment lit (0x00 = blank = 0)
//   one        ones pattern, same format (0x00 is illegal)
//   in_valid   ten/one are meaningful this cycle
//   number     decoded value 0..99, 127 when err
//   out_valid  one-cycle pulse: number/err were just updated
//   err        illegal pattern in the accepted pair (qualified by out_valid)
//   err_cnt    saturating count of erroneous accepts
// ---------------------------------------------------------------------------
module seg_pair_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERRCNT_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          ten,
    input  logic [6:0]          one,
    input  logic                in_valid,
    output logic [6:0]          number,
    output logic                out_valid,
    output logic                err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int CNT_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Returns {illegal, digit}. A blank pattern is a legal 0 only where the
    // caller allows it (tens position, i.e. leading-zero suppression).
    function automatic logic [4:0] seg_to_digit(input logic [6:0] pat,
                                                input logic       blank_ok);
        logic [4:0] r;
        r = {1'b0, 4'd0};
        case (pat)
            7'h3F:   r = {1'b0, 4'd0};
            7'h06:   r = {1'b0, 4'd1};
            7'h5B:   r = {1'b0, 4'd2};
            7'h4F:   r = {1'b0, 4'd3};
            7'h66:   r = {1'b0, 4'd4};
            7'h6D:   r = {1'b0, 4'd5};
            7'h7D:   r = {1'b0, 4'd6};
            7'h07:   r = {1'b0, 4'd7};
            7'h7F:   r = {1'b0, 4'd8};
            7'h6F:   r = {1'b0, 4'd9};
            7'h00:   r = {~blank_ok, 4'd0};
            default: r = {1'b1, 4'd0};
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Stability filter
    // ------------------------------------------------------------------
    logic [13:0]      pair;
    logic [13:0]      held_reg;
    logic [CNT_W-1:0] stab_cnt_reg;
    logic [CNT_W-1:0] stab_cnt_next;
    logic             accept;

    assign pair = {ten, one};

    // accept only fires on the transition into CNT_MAX; once saturated the
    // counter holds and no further accept is produced for the same run.
    always_comb begin
        stab_cnt_next = stab_cnt_reg;
        accept        = 1'b0;
        if (!in_valid) begin
            stab_cnt_next = '0;
        end else if (pair != held_reg || stab_cnt_reg == '0) begin
            stab_cnt_next = CNT_ONE;
            accept        = (CNT_MAX == CNT_ONE);
        end else if (stab_cnt_reg != CNT_MAX) begin
            stab_cnt_next = stab_cnt_reg + 1'b1;
            accept        = ((stab_cnt_reg + 1'b1) == CNT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_reg     <= '0;
            stab_cnt_reg <= '0;
        end else begin
            stab_cnt_reg <= stab_cnt_next;
            // Loading on every valid sample is equivalent to loading only on
            // a change: when the pair is unchanged the value is the same.
            if (in_valid) begin
                held_reg <= pair;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-digit decode: index 0 = ones, index 1 = tens
    // ------------------------------------------------------------------
    logic [7:0] dig_val;
    logic [1:0] dig_bad;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dec
            assign {dig_bad[gi], dig_val[gi*4 +: 4]} =
                seg_to_digit(pair[gi*7 +: 7], (gi == 1) ? 1'b1 : 1'b0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: capture decoded digits on the accept edge
    // ------------------------------------------------------------------
    logic [3:0] tens_d_reg;
    logic [3:0] ones_d_reg;
    logic       ill_t_reg;
    logic       ill_o_reg;
    logic       s1_valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_d_reg   <= '0;
            ones_d_reg   <= '0;
            ill_t_reg    <= 1'b0;
            ill_o_reg    <= 1'b0;
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                tens_d_reg <= dig_val[7:4];
                ones_d_reg <= dig_val[3:0];
                ill_t_reg  <= dig_bad[1];
                ill_o_reg  <= dig_bad[0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: combine digits; number/err hold between pulses
    // ------------------------------------------------------------------
    logic [6:0] number_reg;
    logic       err_reg;
    logic       out_valid_reg;
    logic       s1_bad;
    logic [6:0] s1_sum;

    assign s1_bad = ill_t_reg | ill_o_reg;
    // tens <= 9 so the sum is at most 99 and fits in 7 bits.
    assign s1_sum = 7'(7'(tens_d_reg) * 7'd10 + 7'(ones_d_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            number_reg    <= '0;
            err_reg       <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                err_reg    <= s1_bad;
                number_reg <= s1_bad ? 7'd127 : s1_sum;
            end
        end
    end

    assign number    = number_reg;
    assign err       = err_reg;
    assign out_valid = out_valid_reg;

    // ------------------------------------------------------------------
    // Optional error counter; updates on the same edge that raises an
    // erroneous out_valid, so err_cnt already includes the current pulse.
    // ------------------------------------------------------------------
`ifdef SEGDEC_ERRCNT_EN
    logic [ERRCNT_W-1:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (s1_valid_reg && s1_bad && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_seg_pair_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_pair_decoder
//
// Self-checking bench for seg_pair_decoder. A behavioural model counts the
// length of the current run of identical valid samples and predicts the
// decode pulse one edge after the run reaches STABLE_CYCLES. Every cycle the
// DUT outputs are compared against the model; table vectors and directed
// sequences add hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_seg_pair_decoder;

    localparam int S  = 4;
    localparam int EW = 8;
    localparam int MAXC = (1 << EW) - 1;

    logic          clk;
    logic          rst_n;
    logic [6:0]    ten;
    logic [6:0]    one;
    logic          in_valid;
    logic [6:0]    number;
    logic          out_valid;
    logic          err;
    logic [EW-1:0] err_cnt;

    seg_pair_decoder #(.STABLE_CYCLES(S), .ERRCNT_W(EW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ten       (ten),
        .one       (one),
        .in_valid  (in_valid),
        .number    (number),
        .out_valid (out_valid),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // ---------------- reference model ----------------
    int          run_len;
    logic [13:0] prev_pair;
    bit          pend;
    logic [6:0]  pend_num;
    bit          pend_err;
    bit          e_valid;
    logic [6:0]  e_num;
    bit          e_err;
    int          e_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic ref_decode(input logic [6:0] t, input logic [6:0] o,
                              output logic [6:0] n, output bit e);
        int td;
        int od;
        td = -1;
        od = -1;
        if (t == 7'h00) td = 0;
        for (int k = 0; k < 10; k++) begin
            if (pats[k] == t) td = k;
            if (pats[k] == o) od = k;
        end
        e = (td < 0) || (od < 0);
        n = e ? 7'd127 : 7'(td * 10 + od);
    endtask

    task automatic model_reset();
        run_len = 0;
        prev_pair = '0;
        pend = 0;
        pend_num = '0;
        pend_err = 0;
        e_valid = 0;
        e_num = '0;
        e_err = 0;
        e_cnt = 0;
    endtask

    task automatic model_edge(input logic [6:0] t, input logic [6:0] o, input bit v);
        e_valid = pend;
        if (pend) begin
            e_num = pend_num;
            e_err = pend_err;
            if (pend_err && e_cnt < MAXC) e_cnt++;
        end
        pend = 0;
        if (!v) begin
            run_len = 0;
        end else begin
            if (run_len > 0 && {t, o} == prev_pair) run_len++;
            else run_len = 1;
            prev_pair = {t, o};
            if (run_len == S) begin
                pend = 1;
                ref_decode(t, o, pend_num, pend_err);
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        int exp_cnt;
`ifdef SEGDEC_ERRCNT_EN
        exp_cnt = e_cnt;
`else
        exp_cnt = 0;
`endif
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ".number"}, 32'(number), 32'(e_num));
        chk({tag, ".err"}, 32'(err), 32'(e_err));
        chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_cnt));
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic step(input logic [6:0] t, input logic [6:0] o, input bit v, input string tag);
        ten = t;
        one = o;
        in_valid = v;
        @(posedge clk);
        model_edge(t, o, v);
        #1;
        check_outputs(tag);
        if (v || e_valid)
            $display("cyc t=%0t ten=%h one=%h v=%0b -> ov=%0b num=%0d err=%0b cnt=%0d",
                     $time, t, o, v, out_valid, number, err, err_cnt);
    endtask

    task automatic repeat_pair(input logic [6:0] t, input logic [6:0] o, input int n, input string tag);
        for (int i = 0; i < n; i++) step(t, o, 1'b1, tag);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [6:0] t;
        logic [6:0] o;
        logic [6:0] num;
        logic       e;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{7'h5B, 7'h4F, 7'd23,  1'b0};
        vecs[1]  = '{7'h00, 7'h07, 7'd7,   1'b0};
        vecs[2]  = '{7'h6F, 7'h7F, 7'd98,  1'b0};
        vecs[3]  = '{7'h3F, 7'h3F, 7'd0,   1'b0};
        vecs[4]  = '{7'h06, 7'h01, 7'd127, 1'b1};
        vecs[5]  = '{7'h00, 7'h00, 7'd127, 1'b1};
        vecs[6]  = '{7'h00, 7'h3F, 7'd0,   1'b0};
        vecs[7]  = '{7'h7F, 7'h6F, 7'd89,  1'b0};
        vecs[8]  = '{7'h66, 7'h6D, 7'd45,  1'b0};
        vecs[9]  = '{7'h7D, 7'h07, 7'd67,  1'b0};
        vecs[10] = '{7'h06, 7'h06, 7'd11,  1'b0};
        vecs[11] = '{7'h38, 7'h3F, 7'd127, 1'b1};
    end

    logic [6:0] rpool [14] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                               7'h07, 7'h7F, 7'h6F, 7'h00, 7'h38, 7'h01, 7'h7E};

    initial begin
        logic [6:0] rt;
        logic [6:0] ro;
        int         exp_sat;

        // ---- 1: reset with random inputs ----
        rst_n = 1'b0;
        ten = '0;
        one = '0;
        in_valid = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            ten = 7'($urandom);
            one = 7'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            check_outputs("reset");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(7'h00, 7'h00, 1'b0, "post_reset");

        // ---- 2: 23, one pulse, no repeat while held ----
        repeat_pair(7'h5B, 7'h4F, S, "t2_run");
        step(7'h5B, 7'h4F, 1'b1, "t2_pulse");
        chk("t2_pulse_valid", 32'(out_valid), 32'd1);
        chk("t2_number", 32'(number), 32'd23);
        repeat_pair(7'h5B, 7'h4F, 10, "t2_hold");
        step(7'h00, 7'h00, 1'b0, "t2_idle");

        // ---- 3: leading blank, then interrupted run ----
        repeat_pair(7'h00, 7'h07, S, "t3_run");
        step(7'h00, 7'h00, 1'b0, "t3_pulse");
        chk("t3_number7", 32'(number), 32'd7);
        repeat_pair(7'h6F, 7'h6F, S - 1, "t3_partial");
        repeat_pair(7'h6F, 7'h7F, S, "t3_run98");
        step(7'h00, 7'h00, 1'b0, "t3_pulse98");
        chk("t3_number98", 32'(number), 32'd98);

        // ---- 4: illegal ones digit, err_cnt, saturation ----
        repeat_pair(7'h06, 7'h01, S, "t4_run");
        step(7'h00, 7'h00, 1'b0, "t4_pulse");
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_number", 32'(number), 32'd127);
`ifdef SEGDEC_ERRCNT_EN
        chk("t4_errcnt1", 32'(err_cnt), 32'd1);
        exp_sat = MAXC;
`else
        chk("t4_errcnt0", 32'(err_cnt), 32'd0);
        exp_sat = 0;
`endif
        for (int i = 0; i < (1 << EW) + 2; i++)
            repeat_pair(7'h06, (i % 2 == 0) ? 7'h02 : 7'h01, S, "t4_sat");
        step(7'h00, 7'h00, 1'b0, "t4_tail");
        step(7'h00, 7'h00, 1'b0, "t4_tail");
        chk("t4_saturated", 32'(err_cnt), 32'(exp_sat));

        // ---- 5: in_valid drop restarts filter ----
        repeat_pair(7'h3F, 7'h3F, 2, "t5_a");
        step(7'h3F, 7'h3F, 1'b0, "t5_drop");
        repeat_pair(7'h3F, 7'h3F, S - 1, "t5_b");
        chk("t5_no_early", 32'(out_valid), 32'd0);
        step(7'h3F, 7'h3F, 1'b1, "t5_last");
        step(7'h00, 7'h00, 1'b0, "t5_pulse");
        chk("t5_pulse", 32'(out_valid), 32'd1);
        chk("t5_number0", 32'(number), 32'd0);

        // ---- 6: reset right after the accept edge ----
        repeat_pair(7'h66, 7'h66, S, "t6_run");
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #2;
        check_outputs("t6_in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(7'h00, 7'h00, 1'b0, "t6_after");
        chk("t6_number", 32'(number), 32'd0);

        // ---- table vectors ----
        foreach (vecs[i]) begin
            step(7'h00, 7'h00, 1'b0, "tbl_gap");
            repeat_pair(vecs[i].t, vecs[i].o, S, "tbl_run");
            step(7'h00, 7'h00, 1'b0, "tbl_pulse");
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_number", 32'(number), 32'(vecs[i].num));
            chk("tbl_err", 32'(err), 32'(vecs[i].e));
        end

        // ---- randomized stimulus ----
        rt = 7'h3F;
        ro = 7'h3F;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5) == 0) begin
                rt = rpool[$urandom_range(13)];
                ro = rpool[$urandom_range(13)];
            end
            step(rt, ro, ($urandom_range(9) != 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
